// File: rtl/ifetch_pkg.sv
// Shared bexkat1 definitions: instruction-type codes, fetch FSM states and the
// long-instruction marker used by the instruction fetch unit.
package bexkat1Def;

  typedef enum logic [3:0] {
    T_INH, T_PUSH, T_POP, T_CMP, T_MOV, T_FP, T_ALU, T_INT,
    T_LDIU, T_LDI, T_LOAD, T_STORE, T_BRANCH, T_JUMP
  } insn_type_t;

  typedef enum logic [1:0] {
    FETCH1,  // request opcode word
    FETCH2,  // request extension word
    HOLD,    // complete instruction waiting for stall to clear
    DRAIN    // swallow the ack of a read abandoned by a redirect
  } fetch_state_t;

  localparam int unsigned LONG_BIT = 0;

  function automatic logic is_long(input logic [31:0] word);
    return word[LONG_BIT];
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch unit: reads one- or two-word instructions over a simple
// cyc/stb/ack bus and presents them to decode, with stall and redirect support.
module ifetch
  import bexkat1Def::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_target_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic [31:0] bus_adr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_dat_i,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  lo_word_q, lo_word_d;
  logic [63:0]  buf_ir_q, buf_ir_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [63:0]  ir_d;
  logic [31:0]  pc_d;
  logic         cyc_d;
  logic [31:0]  adr_d;

  logic         ack_ok;
  logic         done;
  logic [31:0]  target;
  logic [31:0]  step;
  logic [63:0]  new_ir;

  // Acks only count against a read we actually have on the bus.
  assign ack_ok    = bus_cyc_o & bus_ack_i;
  assign done      = ack_ok & ((state_q == FETCH1 && !is_long(bus_dat_i)) || state_q == FETCH2);
  assign target    = pc_target_i & ~32'h3;
  assign step      = (state_q == FETCH2) ? 32'd8 : 32'd4;
  assign new_ir    = (state_q == FETCH2) ? {bus_dat_i, lo_word_q} : {32'h0, bus_dat_i};
  assign bus_stb_o = bus_cyc_o;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= FETCH1;
      fetch_pc_q <= RESET_VEC;
      lo_word_q  <= '0;
      buf_ir_q   <= '0;
      buf_pc_q   <= '0;
      ir_o       <= '0;
      pc_o       <= '0;
      bus_cyc_o  <= 1'b0;
      bus_adr_o  <= RESET_VEC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      lo_word_q  <= lo_word_d;
      buf_ir_q   <= buf_ir_d;
      buf_pc_q   <= buf_pc_d;
      ir_o       <= ir_d;
      pc_o       <= pc_d;
      bus_cyc_o  <= cyc_d;
      bus_adr_o  <= adr_d;
    end
  end

  // NOTE: each combinational block assigns a default to every output first, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (pc_set_i) begin
      // A read still in flight must be drained before the target is fetched.
      state_d = (bus_cyc_o && !bus_ack_i) ? DRAIN : FETCH1;
    end else begin
      unique case (state_q)
        FETCH1: if (ack_ok) state_d = is_long(bus_dat_i) ? FETCH2 : (stall_i ? HOLD : FETCH1);
        FETCH2: if (ack_ok) state_d = stall_i ? HOLD : FETCH1;
        HOLD:   if (!stall_i) state_d = FETCH1;
        DRAIN:  if (ack_ok) state_d = FETCH1;
        default: state_d = FETCH1;
      endcase
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    lo_word_d  = lo_word_q;
    buf_ir_d   = buf_ir_q;
    buf_pc_d   = buf_pc_q;
    ir_d       = stall_i ? ir_o : '0;
    pc_d       = pc_o;

    if (pc_set_i) begin
      fetch_pc_d = target;
      lo_word_d  = '0;
      buf_ir_d   = '0;
      ir_d       = '0;
    end else if (done) begin
      fetch_pc_d = fetch_pc_q + step;
      if (stall_i) begin
        buf_ir_d = new_ir;
        buf_pc_d = fetch_pc_q;
      end else begin
        ir_d = new_ir;
        pc_d = fetch_pc_q;
      end
    end else if (state_q == FETCH1 && ack_ok) begin
      lo_word_d = bus_dat_i;
    end else if (state_q == HOLD && !stall_i) begin
      ir_d = buf_ir_q;
      pc_d = buf_pc_q;
    end

    // The bus is idle only while an instruction is parked in HOLD.
    cyc_d = (state_d != HOLD);
    unique case (state_d)
      FETCH1:  adr_d = fetch_pc_d;
      FETCH2:  adr_d = fetch_pc_q + 32'd4;
      default: adr_d = bus_adr_o;
    endcase
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by randomized
// bus latency, stalls and redirects checked against an instruction-stream model.
module tb_ifetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        pc_set_i;
  logic [31:0] pc_target_i;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic [31:0] bus_adr_o;
  logic        bus_ack_i;
  logic [31:0] bus_dat_i;
  logic [63:0] ir_o;
  logic [31:0] pc_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] seed;

  ifetch #(.RESET_VEC(32'h0)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .stall_i    (stall_i),
    .pc_set_i   (pc_set_i),
    .pc_target_i(pc_target_i),
    .bus_cyc_o  (bus_cyc_o),
    .bus_stb_o  (bus_stb_o),
    .bus_adr_o  (bus_adr_o),
    .bus_ack_i  (bus_ack_i),
    .bus_dat_i  (bus_dat_i),
    .ir_o       (ir_o),
    .pc_o       (pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one acked word; returns at the following negedge with outputs settled.
  task automatic ack_word(input logic [31:0] d);
    bus_ack_i = 1'b1;
    bus_dat_i = d;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    bus_dat_i = '0;
  endtask

  // Program memory: pseudo-random contents, opcode words never zero.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E3779B1) ^ seed;
    w = w ^ (w >> 13);
    return w | 32'h2;
  endfunction

  function automatic logic [63:0] insn_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
    return w[0] ? {mem_word(pc + 32'd4), w} : {32'h0, w};
  endfunction

  initial begin
    logic [63:0] m_ir;
    logic [31:0] m_pc, exp_pc, p_tgt;
    logic        p_set, p_stall;
    int          delivered;

    seed        = $urandom;
    rst_i       = 1'b1;
    stall_i     = 1'b0;
    pc_set_i    = 1'b0;
    pc_target_i = '0;
    bus_ack_i   = 1'b0;
    bus_dat_i   = '0;

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_cyc", bus_cyc_o, 0);
    check("rst_stb", bus_stb_o, 0);
    check("rst_adr", bus_adr_o, 32'h0);
    check("rst_ir", ir_o, 0);
    check("rst_pc", pc_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("first_req_stb", bus_stb_o, 1);
    check("first_req_adr", bus_adr_o, 32'h0);

    // Reset vector, short instruction
    ack_word(32'h1000_0000);
    check("rv_ir", ir_o, 64'h0000_0000_1000_0000);
    check("rv_pc", pc_o, 32'h0);
    check("rv_next_adr", bus_adr_o, 32'h4);
    ack_word(32'h0000_0002);
    check("short4_ir", ir_o, 64'h2);
    check("short4_next_adr", bus_adr_o, 32'h8);

    // Long instruction
    ack_word(32'h7010_0001);
    check("long_ext_adr", bus_adr_o, 32'hC);
    check("long_mid_bubble", ir_o, 0);
    ack_word(32'hDEAD_BEEF);
    check("long_ir", ir_o, 64'hDEADBEEF_70100001);
    check("long_pc", pc_o, 32'h8);
    check("long_next_adr", bus_adr_o, 32'h10);

    // Completion under a 3-cycle stall
    stall_i = 1'b1;
    ack_word(32'h0000_0004);
    check("stall_ir_hold0", ir_o, 64'hDEADBEEF_70100001);
    check("stall_no_stb0", bus_stb_o, 0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_ir_hold", ir_o, 64'hDEADBEEF_70100001);
      check("stall_no_stb", bus_stb_o, 0);
    end
    stall_i = 1'b0;
    @(negedge clk_i);
    check("unstall_ir", ir_o, 64'h4);
    check("unstall_pc", pc_o, 32'h10);
    check("unstall_adr", bus_adr_o, 32'h14);
    check("unstall_stb", bus_stb_o, 1);
    @(negedge clk_i);
    check("idle_bubble", ir_o, 0);

    // Redirect while a read is in flight
    pc_set_i    = 1'b1;
    pc_target_i = 32'h400;
    @(negedge clk_i);
    pc_set_i = 1'b0;
    check("drain_bubble", ir_o, 0);
    check("drain_stb", bus_stb_o, 1);
    ack_word(32'h0000_0044);
    check("drain_discard_ir", ir_o, 0);
    check("drain_target_adr", bus_adr_o, 32'h400);
    ack_word(32'h0000_0010);
    check("target_ir", ir_o, 64'h10);
    check("target_pc", pc_o, 32'h400);

    // Redirect coincident with extension-word ack, unaligned target
    ack_word(32'h0000_0021);
    check("half_ext_adr", bus_adr_o, 32'h408);
    pc_set_i    = 1'b1;
    pc_target_i = 32'h803;
    ack_word(32'hCAFE_BABE);
    pc_set_i = 1'b0;
    check("half_drop_ir", ir_o, 0);
    check("half_target_adr", bus_adr_o, 32'h800);
    ack_word(32'h0000_0006);
    check("half_next_ir", ir_o, 64'h6);
    check("half_next_pc", pc_o, 32'h800);

    // Address wrap
    pc_set_i    = 1'b1;
    pc_target_i = 32'hFFFF_FFFC;
    ack_word(32'h0000_2222);
    pc_set_i = 1'b0;
    check("wrap_req_adr", bus_adr_o, 32'hFFFF_FFFC);
    ack_word(32'h0000_0008);
    check("wrap_ir", ir_o, 64'h8);
    check("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check("wrap_next_adr", bus_adr_o, 32'h0);

    // Second redirect during DRAIN replaces the target
    pc_set_i    = 1'b1;
    pc_target_i = 32'h100;
    @(negedge clk_i);
    pc_target_i = 32'h200;
    @(negedge clk_i);
    pc_set_i = 1'b0;
    check("drain2_stb", bus_stb_o, 1);
    ack_word(32'h0000_0030);
    check("drain2_adr", bus_adr_o, 32'h200);
    check("drain2_ir", ir_o, 0);

    // Reset mid-read, then a stray ack as reset releases
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_cyc", bus_cyc_o, 0);
    check("async_rst_stb", bus_stb_o, 0);
    check("async_rst_adr", bus_adr_o, 32'h0);
    check("async_rst_ir", ir_o, 0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    bus_ack_i = 1'b1;
    bus_dat_i = 32'h0000_0055;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    bus_dat_i = '0;
    check("stray_ir", ir_o, 0);
    check("stray_adr", bus_adr_o, 32'h0);
    check("stray_stb", bus_stb_o, 1);
    ack_word(32'h0000_0040);
    check("post_rst_ir", ir_o, 64'h40);
    check("post_rst_pc", pc_o, 32'h0);

    // Randomized phase against the instruction-stream model
    m_ir      = 64'h40;
    m_pc      = 32'h0;
    exp_pc    = 32'h0;
    p_set     = 1'b0;
    p_stall   = 1'b0;
    p_tgt     = '0;
    delivered = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) begin
        @(negedge clk_i);
        check("rnd_stb_eq_cyc", bus_stb_o, bus_cyc_o);
        if (p_set) begin
          check("rnd_redirect_ir", ir_o, 0);
          check("rnd_redirect_pc", pc_o, m_pc);
          m_ir   = '0;
          exp_pc = p_tgt & ~32'h3;
        end else if (p_stall) begin
          check("rnd_stall_ir", ir_o, m_ir);
          check("rnd_stall_pc", pc_o, m_pc);
        end else if (ir_o == 64'h0) begin
          check("rnd_bubble_pc", pc_o, m_pc);
          m_ir = '0;
        end else begin
          m_ir = insn_at(exp_pc);
          m_pc = exp_pc;
          check("rnd_ir", ir_o, m_ir);
          check("rnd_pc", pc_o, m_pc);
          exp_pc = exp_pc + (m_ir[0] ? 32'd8 : 32'd4);
          delivered++;
        end
      end
      p_set   = (n == 0) || ($urandom_range(0, 24) == 0);
      p_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) p_tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else p_tgt = $urandom & 32'h0000_3FFF;
      pc_set_i    = p_set;
      pc_target_i = p_tgt;
      stall_i     = p_stall;
      bus_ack_i   = bus_stb_o && ($urandom_range(0, 1) == 1);
      bus_dat_i   = bus_ack_i ? mem_word(bus_adr_o) : $urandom;
    end
    @(negedge clk_i);
    pc_set_i  = 1'b0;
    stall_i   = 1'b0;
    bus_ack_i = 1'b0;
    check("rnd_progress", 64'(delivered >= 100), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
